// File: rtl/salsa20_round_sequencer.sv
// salsa20_round_sequencer: iterative Salsa20 core, one column/row round per cycle, final word-wise feed-forward add.
// Ports:
//   clk_i        clock, rising edge
//   rst_ni       asynchronous active-low reset
//   in_valid_i   in_data_i carries a block
//   in_ready_o   idle, a block can be accepted
//   in_data_i    512-bit input block, word i at [32i+31:32i]
//   out_valid_o  out_data_o holds a finished keystream block
//   out_ready_i  consumer accepts out_data_o
//   out_data_o   512-bit keystream block, same word order as in_data_i
//   busy_o       block in flight or waiting to be taken
module salsa20_round_sequencer #(
    parameter int ROUNDS = 20
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         in_valid_i,
    output logic         in_ready_o,
    input  logic [511:0] in_data_i,
    output logic         out_valid_o,
    input  logic         out_ready_i,
    output logic [511:0] out_data_o,
    output logic         busy_o
);
    if (ROUNDS < 2 || ROUNDS % 2 != 0) begin : g_bad_rounds
        $error("ROUNDS must be even and at least 2");
    end

    localparam int RW = $clog2(ROUNDS);

    typedef enum logic [1:0] {IDLE, RUN, DONE} fsm_t;

    fsm_t               fsm_q, fsm_d;
    logic [15:0][31:0]  blk_q, blk_d, orig_q, orig_d, out_q, out_d, nxt, sum;
    logic [RW-1:0]      rnd_q, rnd_d;
    logic               last;

    function automatic logic [31:0] rotl(input logic [31:0] x, input int n);
        return (x << n) | (x >> (32 - n));
    endfunction

    // Returns {z3, z2, z1, z0}.
    function automatic logic [127:0] qr(input logic [31:0] y0, y1, y2, y3);
        logic [31:0] z0, z1, z2, z3;
        z1 = y1 ^ rotl(y0 + y3, 7);
        z2 = y2 ^ rotl(z1 + y0, 9);
        z3 = y3 ^ rotl(z2 + z1, 13);
        z0 = y0 ^ rotl(z3 + z2, 18);
        return {z3, z2, z1, z0};
    endfunction

    function automatic logic [15:0][31:0] odd_round(input logic [15:0][31:0] x);
        logic [15:0][31:0] y;
        {y[12], y[8],  y[4],  y[0]}  = qr(x[0],  x[4],  x[8],  x[12]);
        {y[1],  y[13], y[9],  y[5]}  = qr(x[5],  x[9],  x[13], x[1]);
        {y[6],  y[2],  y[14], y[10]} = qr(x[10], x[14], x[2],  x[6]);
        {y[11], y[7],  y[3],  y[15]} = qr(x[15], x[3],  x[7],  x[11]);
        return y;
    endfunction

    function automatic logic [15:0][31:0] even_round(input logic [15:0][31:0] x);
        logic [15:0][31:0] y;
        {y[3],  y[2],  y[1],  y[0]}  = qr(x[0],  x[1],  x[2],  x[3]);
        {y[4],  y[7],  y[6],  y[5]}  = qr(x[5],  x[6],  x[7],  x[4]);
        {y[9],  y[8],  y[11], y[10]} = qr(x[10], x[11], x[8],  x[9]);
        {y[14], y[13], y[12], y[15]} = qr(x[15], x[12], x[13], x[14]);
        return y;
    endfunction

    // Even round index means a column round (rounds 1, 3, 5, ... counting from one).
    assign nxt  = rnd_q[0] ? even_round(blk_q) : odd_round(blk_q);
    assign last = rnd_q == RW'(ROUNDS - 1);

    always_comb begin
        for (int i = 0; i < 16; i++) sum[i] = nxt[i] + orig_q[i];
    end

    always_comb begin
        fsm_d  = fsm_q;
        blk_d  = blk_q;
        orig_d = orig_q;
        rnd_d  = rnd_q;
        out_d  = out_q;
        case (fsm_q)
            IDLE: if (in_valid_i) begin
                blk_d  = in_data_i;
                orig_d = in_data_i;
                rnd_d  = '0;
                fsm_d  = RUN;
            end
            RUN: if (last) begin
                out_d = sum;
                fsm_d = DONE;
            end else begin
                blk_d = nxt;
                rnd_d = rnd_q + RW'(1);
            end
            DONE: fsm_d = out_ready_i ? IDLE : DONE;
            default: fsm_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            fsm_q  <= IDLE;
            blk_q  <= '0;
            orig_q <= '0;
            rnd_q  <= '0;
            out_q  <= '0;
        end else begin
            fsm_q  <= fsm_d;
            blk_q  <= blk_d;
            orig_q <= orig_d;
            rnd_q  <= rnd_d;
            out_q  <= out_d;
        end
    end

    assign in_ready_o  = fsm_q == IDLE;
    assign out_valid_o = fsm_q == DONE;
    assign busy_o      = fsm_q != IDLE;
    assign out_data_o  = out_q;
endmodule

// File: tb/tb_salsa20_round_sequencer.sv
// tb_salsa20_round_sequencer: self-checking bench for salsa20_round_sequencer (Salsa20/20 and Salsa20/2 instances).
module tb_salsa20_round_sequencer;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n;
    logic         a_iv, a_ir, a_ov, a_or, a_busy;
    logic [511:0] a_id, a_od;
    logic         b_iv, b_ir, b_ov, b_or, b_busy;
    logic [511:0] b_id, b_od;

    salsa20_round_sequencer #(.ROUNDS(20)) dut_a (
        .clk_i(clk), .rst_ni(rst_n), .in_valid_i(a_iv), .in_ready_o(a_ir), .in_data_i(a_id),
        .out_valid_o(a_ov), .out_ready_i(a_or), .out_data_o(a_od), .busy_o(a_busy)
    );
    salsa20_round_sequencer #(.ROUNDS(2)) dut_b (
        .clk_i(clk), .rst_ni(rst_n), .in_valid_i(b_iv), .in_ready_o(b_ir), .in_data_i(b_id),
        .out_valid_o(b_ov), .out_ready_i(b_or), .out_data_o(b_od), .busy_o(b_busy)
    );

    typedef struct {
        string        name;
        logic [511:0] din;
        logic [511:0] exp;
    } vec_t;

    int checks = 0, failures = 0, cyc = 0;
    logic [511:0] qa[$], qb[$];
    int a_oc[$], b_oc[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic fail_now(input string nm);
        checks++;
        failures++;
        $display("FAIL %s", nm);
    endtask

    function automatic int unsigned rl(input int unsigned v, input int s);
        return (v << s) | (v >> (32 - s));
    endfunction

    // Software reference: Salsa20 with an arbitrary round count.
    function automatic logic [511:0] model(input int rounds, input logic [511:0] din);
        int unsigned x[16];
        int col[16] = '{0, 4, 8, 12, 5, 9, 13, 1, 10, 14, 2, 6, 15, 3, 7, 11};
        int row[16] = '{0, 1, 2, 3, 5, 6, 7, 4, 10, 11, 8, 9, 15, 12, 13, 14};
        logic [511:0] r;
        int a, b, c, d;
        for (int i = 0; i < 16; i++) x[i] = din[32*i +: 32];
        for (int n = 0; n < rounds; n++) begin
            for (int q = 0; q < 4; q++) begin
                a = (n % 2 == 0) ? col[4*q]   : row[4*q];
                b = (n % 2 == 0) ? col[4*q+1] : row[4*q+1];
                c = (n % 2 == 0) ? col[4*q+2] : row[4*q+2];
                d = (n % 2 == 0) ? col[4*q+3] : row[4*q+3];
                x[b] = x[b] ^ rl(x[a] + x[d], 7);
                x[c] = x[c] ^ rl(x[b] + x[a], 9);
                x[d] = x[d] ^ rl(x[c] + x[b], 13);
                x[a] = x[a] ^ rl(x[d] + x[c], 18);
            end
        end
        for (int i = 0; i < 16; i++) r[32*i +: 32] = x[i] + din[32*i +: 32];
        return r;
    endfunction

    function automatic logic [511:0] rnd512();
        logic [511:0] r;
        for (int i = 0; i < 16; i++) r[32*i +: 32] = $urandom;
        return r;
    endfunction

    // Scoreboard: pop and compare on every output handshake.
    always @(negedge clk) begin
        if (rst_n && a_ov && a_or) begin
            a_oc.push_back(cyc);
            if (qa.size() == 0) fail_now("sb_a unexpected output");
            else chk("sb_a", a_od, qa.pop_front());
        end
        if (rst_n && b_ov && b_or) begin
            b_oc.push_back(cyc);
            if (qb.size() == 0) fail_now("sb_b unexpected output");
            else chk("sb_b", b_od, qb.pop_front());
        end
    end

    // Call only at #1 after a rising edge; leaves in_valid asserted; acc = accept edge index.
    task automatic send(input bit use_b, input logic [511:0] d, input logic [511:0] e, output int acc);
        logic rdy;
        if (use_b) begin qb.push_back(e); b_id = d; b_iv = 1'b1; end
        else begin qa.push_back(e); a_id = d; a_iv = 1'b1; end
        for (int n = 0; n < 100; n++) begin
            rdy = use_b ? b_ir : a_ir;
            @(posedge clk); #1;
            if (rdy) begin
                acc = cyc;
                return;
            end
        end
        acc = -1;
        fail_now("send timeout");
    endtask

    task automatic drain(input bit use_b, input int bound);
        for (int n = 0; n < bound; n++) begin
            if ((use_b ? qb.size() : qa.size()) == 0) return;
            @(posedge clk); #1;
        end
        fail_now("drain timeout");
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    byte unsigned kin[64] = '{
        211,159, 13,115, 76, 55, 82,183,  3,117,222, 37,191,187,234,136,
         49,237,179, 48,  1,106,178,219,175,199,166, 48, 86, 16,179,207,
         31,240, 32, 63, 15, 83, 93,161,116,147, 48,113,238, 55,204, 36,
         79,201,235, 79,  3, 81,156, 47,203, 26,244,243, 88,118,104, 54};
    byte unsigned kout[64] = '{
        109, 42,178,168,156,240,248,238,168,196,190,203, 26,110,170,154,
         29, 29,150, 26,150, 30,235,249,190,163,251, 48, 69,144, 51, 57,
        118, 40,152,157,180, 57, 27, 94,107, 42,236, 35, 27,111,114,114,
        219,236,232,135,111,155,110, 18, 24,232, 95,158,179, 19, 48,202};

    initial begin
        vec_t va[3];
        vec_t vb[3];
        logic [511:0] d, held;
        int acc, rel;

        va[0].name = "zero_block";
        va[0].din  = '0;
        va[0].exp  = '0;
        va[1].name = "known_answer";
        for (int k = 0; k < 64; k++) begin
            va[1].din[8*k +: 8] = kin[k];
            va[1].exp[8*k +: 8] = kout[k];
        end
        va[2].name = "random20";
        va[2].din  = rnd512();
        va[2].exp  = model(20, va[2].din);
        vb[0].name = "random2";
        vb[0].din  = rnd512();
        vb[0].exp  = model(2, vb[0].din);
        vb[1].name = "all_ones2";
        vb[1].din  = {512{1'b1}};
        vb[1].exp  = model(2, vb[1].din);
        vb[2].name = "mixed2";
        vb[2].din  = {8{64'hFFFF_FFFF_0000_0001}};
        vb[2].exp  = model(2, vb[2].din);

        rst_n = 1'b0;
        a_iv = 1'b0; a_id = '0; a_or = 1'b1;
        b_iv = 1'b0; b_id = '0; b_or = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", a_ir, 1);
        chk("rst_out_valid", a_ov, 0);
        chk("rst_busy", a_busy, 0);
        chk("rst_out_data", a_od, 0);
        chk("rst_b_in_ready", b_ir, 1);
        rst_n = 1'b1;

        foreach (vb[i]) begin
            b_oc.delete();
            send(1'b1, vb[i].din, vb[i].exp, acc);
            b_iv = 1'b0;
            drain(1'b1, 50);
            if (b_oc.size() == 1) chk({vb[i].name, "_latency"}, b_oc[0] - acc, 2);
            else fail_now({vb[i].name, " missing output"});
        end

        foreach (va[i]) begin
            a_oc.delete();
            send(1'b0, va[i].din, va[i].exp, acc);
            a_iv = 1'b0;
            chk({va[i].name, "_busy"}, a_busy, 1);
            drain(1'b0, 100);
            if (a_oc.size() == 1) chk({va[i].name, "_latency"}, a_oc[0] - acc, 20);
            else fail_now({va[i].name, " missing output"});
        end

        a_or = 1'b0;
        d = rnd512();
        send(1'b0, d, model(20, d), acc);
        a_iv = 1'b0;
        for (int n = 0; n < 40 && !a_ov; n++) begin
            @(posedge clk); #1;
        end
        chk("bp_valid", a_ov, 1);
        chk("bp_latency", cyc - acc, 20);
        held = a_od;
        for (int k = 0; k < 10; k++) begin
            a_iv = (k == 3);
            a_id = ~d;
            @(posedge clk); #1;
            chk("bp_data_stable", a_od, held);
            chk("bp_in_ready_low", a_ir, 0);
            chk("bp_valid_held", a_ov, 1);
        end
        a_iv = 1'b0;
        a_or = 1'b1;
        @(posedge clk); #1;
        chk("bp_release_in_ready", a_ir, 1);
        chk("bp_release_valid", a_ov, 0);
        chk("bp_release_busy", a_busy, 0);
        chk("bp_queue_empty", qa.size(), 0);
        repeat (5) @(posedge clk);
        #1;
        chk("bp_pulse_ignored", {a_ov, a_busy}, 0);

        a_oc.delete();
        for (int j = 0; j < 3; j++) begin
            d = rnd512();
            send(1'b0, d, model(20, d), acc);
        end
        a_iv = 1'b0;
        drain(1'b0, 200);
        chk("b2b_count", a_oc.size(), 3);
        if (a_oc.size() == 3) begin
            chk("b2b_spacing_1", a_oc[1] - a_oc[0], 22);
            chk("b2b_spacing_2", a_oc[2] - a_oc[1], 22);
        end

        d = rnd512();
        send(1'b0, d, model(20, d), acc);
        a_iv = 1'b0;
        repeat (7) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_in_ready", a_ir, 1);
        chk("mid_rst_out_valid", a_ov, 0);
        chk("mid_rst_busy", a_busy, 0);
        chk("mid_rst_out_data", a_od, 0);
        qa.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        rel = cyc;
        a_oc.delete();
        d = rnd512();
        send(1'b0, d, model(20, d), acc);
        a_iv = 1'b0;
        chk("post_rst_accept_edge", acc, rel + 1);
        drain(1'b0, 100);
        if (a_oc.size() == 1) chk("post_rst_latency", a_oc[0] - acc, 20);
        else fail_now("post_rst missing output");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/salsa20_round_sequencer.md
# salsa20_round_sequencer

Iterative Salsa20 core controller. It accepts a 512-bit input block over a valid/ready handshake and time-multiplexes one column-round instance (`odd_round`) and one row-round instance (`even_round`) over a single state register, one round per cycle. After `ROUNDS` rounds it adds the original input word-wise and presents the 512-bit keystream block over a valid/ready handshake. It sits between the key/nonce/counter block builder and the keystream XOR stage.

## Interface
- `ROUNDS`, 20, number of rounds. Legal values are even and ≥2, so 8, 12 and 20 give Salsa20/8, /12 and /20. Any other value is a synthesis-time error.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst_n` input 1: reset, asynchronous and active-low.
- `in_valid` input 1: `in_data` carries a block to process.
- `in_ready` output 1: the block is idle and can accept a block.
- `in_data` input 512: input block. Word i is bits [32i+31:32i], for i = 0..15.
- `out_valid` output 1: `out_data` holds a finished keystream block.
- `out_ready` input 1: the consumer accepts `out_data`.
- `out_data` output 512: keystream block, with the same word ordering as `in_data`.
- `busy` output 1: high in RUN and DONE.

## Operation
- State machine with three states: IDLE, RUN and DONE. Reset enters IDLE.
- IDLE
  - `in_ready`=1.
  - On `in_valid`&`in_ready`: capture `in_data` into both `state` and `orig`, set `rnd`=0, go to RUN.
- RUN, each cycle:
  - Compute `next` as `odd_round(state)` when `rnd` is even (rounds 1, 3, 5, … are column rounds), otherwise `even_round(state)`.
  - If `rnd` < `ROUNDS`-1: `state`<=`next`, `rnd`<=`rnd`+1.
  - If `rnd` = `ROUNDS`-1: `out_data`<=`next`+`orig` word-wise, go to DONE.
- Word-wise addition: `out_data[i]` = (`next[i]` + `orig[i]`) mod 2^32. Carries never cross word boundaries.
- DONE
  - `out_valid`=1. `out_data` is held stable until accepted.
  - On `out_ready`: go to IDLE.
  - `in_ready` stays 0 in DONE. A new input is not accepted in the same cycle the output is taken.
- `rnd` counter is $clog2(`ROUNDS`) bits. It never wraps in normal operation and is cleared on every accept.
- `in_data` is ignored outside IDLE. `in_valid` may be held high without effect while busy.
- `out_ready` is ignored outside DONE.

## Timing
- Reset values: `in_ready`=1, `out_valid`=0, `busy`=0, `out_data`=0. Internal `state`, `orig` and `rnd` are also 0, and the FSM is in IDLE.
- Acceptance at rising edge E0 places the FSM in RUN after E0.
- `out_valid` rises after edge E`ROUNDS`. Latency from accept to `out_valid` is `ROUNDS` cycles (20 for the default).
- Output accepted at edge Ex: `in_ready` is 1 after Ex. The next accept is at Ex+1 at the earliest.
- Maximum throughput is one block per `ROUNDS`+2 cycles when `out_ready` is held high.
- `out_valid`, once high, must not drop until a cycle with `out_ready`=1. `out_data` must not change while `out_valid`=1.
- Reset asserted mid-RUN or mid-DONE:
  - Immediately (asynchronously) force IDLE, `out_valid`=0 and `out_data`=0.
  - The in-flight block is discarded. No partial result is ever presented.
- Reset deassertion takes effect on the first rising edge with `rst_n`=1. `in_valid` high at that edge is accepted.
- Critical path is one quarter-round chain, four add-rotate-xor stages, plus the 32-bit final adder on the last round.

## Test plan
- Zero block: `in_data`=0, `ROUNDS`=20 → `out_data`=0, with `out_valid` rising exactly 20 cycles after the accept edge.
- Known answer: the Salsa20/20 hash example from the Salsa20 specification (section 8 input words) → the specification's 16 output words, bit-exact, in word order 0..15.
- Round alternation: `ROUNDS`=2, random block → `out_data` = `even_round(odd_round(in))` + `in` word-wise per a software model. Check carry wrap using words 0xFFFFFFFF+1 → 0x00000000.
- Backpressure: hold `out_ready`=0 for 10 cycles after `out_valid` → `out_data` stable, `in_ready`=0 throughout, and a new `in_valid` pulse is ignored. Then `out_ready`=1 → IDLE next cycle.
- Back-to-back: 3 random blocks with `in_valid`/`out_ready` always 1 → 3 correct outputs spaced 22 cycles apart, in order.
- Reset mid-run: assert `rst_n`=0 at round 7 → outputs return to reset values with no clock edge. After release, a fresh block produces the correct result with no residue from the aborted block.
